// File: rtl/ddr_req_arbiter.sv
// ddr_req_arbiter: merges the cache and bypass requesters onto one DDR af/wdf pair,
// holding a round-robin grant for a whole transaction with a combinational datapath.
module ddr_req_arbiter #(
    parameter int ADDR_W = 31,
    parameter int DATA_W = 128,
    parameter int MASK_W = 16,
    parameter int BEATS  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req,
    input  logic [1:0]            is_rd,
    input  logic [2*ADDR_W-1:0]   rq_af_addr_din,
    input  logic [1:0]            rq_af_wr_en,
    input  logic [2*DATA_W-1:0]   rq_wdf_din,
    input  logic [2*MASK_W-1:0]   rq_wdf_mask_din,
    input  logic [1:0]            rq_wdf_wr_en,
    output logic [1:0]            rq_af_full,
    output logic [1:0]            rq_wdf_full,
    output logic [1:0]            grant,
    input  logic                  af_full,
    input  logic                  wdf_full,
    output logic [ADDR_W-1:0]     af_addr_din,
    output logic                  af_wr_en,
    output logic [DATA_W-1:0]     wdf_din,
    output logic [MASK_W-1:0]     wdf_mask_din,
    output logic                  wdf_wr_en,
    output logic                  proto_err
);
    localparam int CW = $clog2(BEATS + 1);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t r_state, w_state;
    logic [1:0] r_grant, w_grant, w_cand;
    logic r_rd_lat, w_rd_lat, r_af_done, w_af_done, r_last, w_last, r_proto_err, w_proto_err;
    logic [CW-1:0] r_cnt, w_cnt, w_cnt_inc;
    logic w_af_push, w_wdf_push, w_beats_full, w_af_acc, w_wdf_acc, w_done, w_pick;
    always_comb begin
        w_af_push    = |(r_grant & rq_af_wr_en);
        w_wdf_push   = |(r_grant & rq_wdf_wr_en);
        w_beats_full = r_cnt == CW'(BEATS);
        w_af_acc     = w_af_push & ~af_full & ~r_af_done;
        // Reads carry no data and a write never carries more than BEATS beats.
        w_wdf_acc    = w_wdf_push & ~wdf_full & ~r_rd_lat & ~w_beats_full;
        w_proto_err  = r_proto_err | (|(~r_grant & (rq_af_wr_en | rq_wdf_wr_en)))
                     | (w_af_push & r_af_done) | (w_wdf_push & (r_rd_lat | w_beats_full));
        w_cnt_inc    = r_cnt + CW'(w_wdf_acc);
        w_done       = (r_state == BUSY) & (r_rd_lat ? w_af_acc
                     : (r_af_done | w_af_acc) & (w_cnt_inc == CW'(BEATS)));
        // On completion only the other requester may take over without an idle cycle.
        w_cand       = (r_state == IDLE) ? req : w_done ? req & ~r_grant : 2'b00;
        w_pick       = (&w_cand) ? ~r_last : w_cand[1];
        w_state      = r_state;
        w_grant      = r_grant;
        w_rd_lat     = r_rd_lat;
        w_last       = r_last;
        w_af_done    = r_af_done | w_af_acc;
        w_cnt        = w_cnt_inc;
        if (w_done) begin
            w_state   = IDLE;
            w_grant   = 2'b00;
            w_af_done = 1'b0;
            w_cnt     = '0;
        end
        if (|w_cand) begin
            w_state  = BUSY;
            w_grant  = w_pick ? 2'b10 : 2'b01;
            w_rd_lat = is_rd[w_pick];
            w_last   = w_pick;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_grant     <= 2'b00;
            r_rd_lat    <= 1'b0;
            r_af_done   <= 1'b0;
            r_cnt       <= '0;
            r_last      <= 1'b1;
            r_proto_err <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_grant     <= w_grant;
            r_rd_lat    <= w_rd_lat;
            r_af_done   <= w_af_done;
            r_cnt       <= w_cnt;
            r_last      <= w_last;
            r_proto_err <= w_proto_err;
        end
    end
    always_comb begin
        grant        = r_grant;
        proto_err    = r_proto_err;
        rq_af_full   = ~r_grant | {2{af_full}};
        rq_wdf_full  = ~r_grant | {2{wdf_full}};
        af_wr_en     = w_af_acc;
        wdf_wr_en    = w_wdf_acc;
        af_addr_din  = r_grant[1] ? rq_af_addr_din[ADDR_W +: ADDR_W]
                     : r_grant[0] ? rq_af_addr_din[0 +: ADDR_W] : '0;
        wdf_din      = r_grant[1] ? rq_wdf_din[DATA_W +: DATA_W]
                     : r_grant[0] ? rq_wdf_din[0 +: DATA_W] : '0;
        wdf_mask_din = r_grant[1] ? rq_wdf_mask_din[MASK_W +: MASK_W]
                     : r_grant[0] ? rq_wdf_mask_din[0 +: MASK_W] : '0;
    end
endmodule

// File: tb/tb_ddr_req_arbiter.sv
// tb_ddr_req_arbiter: directed test-plan scenarios, then two random requester agents
// checked by a transaction-level scoreboard on the controller side.
module tb_ddr_req_arbiter;
    localparam int AW = 31, DW = 128, MW = 16;
    logic clk = 1'b0, rst;
    logic [1:0] req, is_rd, af_we, wd_we, rq_af_full, rq_wdf_full, grant;
    logic [2*AW-1:0] af_d;
    logic [2*DW-1:0] wd_d;
    logic [2*MW-1:0] wm_d;
    logic af_full, wdf_full, af_wr_en, wdf_wr_en, proto_err;
    logic [AW-1:0] af_addr_din;
    logic [DW-1:0] wdf_din;
    logic [MW-1:0] wdf_mask_din;
    int n_chk = 0, n_pass = 0;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1;
    logic [MW-1:0] m0, m1;
    bit act[2], rd_t[2], af_s[2], acc_af[2], acc_wd[2];
    int gap[2], bs[2], wt[2], ndone[2];
    int max_wt, own, exp_nx, sb_b, tg;
    bit sb_rd, sb_af;
    logic [AW-1:0] t_a[2];
    logic [DW-1:0] t_d[2][2];
    logic [MW-1:0] t_m[2][2];

    ddr_req_arbiter dut (
        .clk(clk), .rst(rst), .req(req), .is_rd(is_rd),
        .rq_af_addr_din(af_d), .rq_af_wr_en(af_we), .rq_wdf_din(wd_d),
        .rq_wdf_mask_din(wm_d), .rq_wdf_wr_en(wd_we), .rq_af_full(rq_af_full),
        .rq_wdf_full(rq_wdf_full), .grant(grant), .af_full(af_full), .wdf_full(wdf_full),
        .af_addr_din(af_addr_din), .af_wr_en(af_wr_en), .wdf_din(wdf_din),
        .wdf_mask_din(wdf_mask_din), .wdf_wr_en(wdf_wr_en), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic logic [127:0] rnd();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic push(input int i, input bit a, input bit w, input logic [AW-1:0] ad,
                        input logic [DW-1:0] d, input logic [MW-1:0] m);
        af_we[i] = a;
        wd_we[i] = w;
        af_d[i*AW +: AW] = ad;
        wd_d[i*DW +: DW] = d;
        wm_d[i*MW +: MW] = m;
    endtask

    task automatic clr();
        af_we = 2'b00;
        wd_we = 2'b00;
    endtask

    task automatic newvals();
        a0 = AW'(rnd()); a1 = AW'(rnd());
        d0 = rnd(); d1 = rnd();
        m0 = MW'(rnd()); m1 = MW'(rnd());
    endtask

    task automatic start(input int t);
        if (own < 0) begin
            own = t;
            if (exp_nx >= 0) chk("rr_order", 128'(t), 128'(exp_nx));
            sb_rd = rd_t[t];
            sb_af = 1'b0;
            sb_b = 0;
        end else chk("interleave", 128'(t), 128'(own));
    endtask

    initial begin
        rst = 1'b1; req = 0; is_rd = 0; af_we = 0; wd_we = 0; af_d = 0; wd_d = 0; wm_d = 0;
        af_full = 0; wdf_full = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_grant", 128'(grant), 128'(2'b00));
        chk("rst_af_we", 128'(af_wr_en), 128'(0));
        chk("rst_wdf_we", 128'(wdf_wr_en), 128'(0));
        chk("rst_af_full", 128'(rq_af_full), 128'(2'b11));
        chk("rst_wdf_full", 128'(rq_wdf_full), 128'(2'b11));
        chk("rst_perr", 128'(proto_err), 128'(0));
        rst = 1'b0;
        // single bypass write
        newvals();
        @(negedge clk); req = 2'b10; #1;
        chk("arb_latency", 128'(grant), 128'(2'b00));
        @(negedge clk); #1;
        chk("byp_grant", 128'(grant), 128'(2'b10));
        push(1, 1, 1, a0, d0, m0); #1;
        chk("byp_af_we", 128'(af_wr_en), 128'(1));
        chk("byp_wdf_we0", 128'(wdf_wr_en), 128'(1));
        chk("byp_addr", 128'(af_addr_din), 128'(a0));
        chk("byp_data0", wdf_din, d0);
        chk("byp_mask0", 128'(wdf_mask_din), 128'(m0));
        chk("byp_rq_af_full", 128'(rq_af_full), 128'(2'b01));
        @(negedge clk); push(1, 0, 1, a0, d1, m1); req = 2'b00; #1;
        chk("byp_af_we1", 128'(af_wr_en), 128'(0));
        chk("byp_wdf_we1", 128'(wdf_wr_en), 128'(1));
        chk("byp_data1", wdf_din, d1);
        @(negedge clk); clr(); #1;
        chk("byp_release", 128'(grant), 128'(2'b00));
        chk("idle_addr", 128'(af_addr_din), 128'(0));
        // asynchronous reset in the middle of a cache transaction
        newvals();
        req = 2'b01;
        @(negedge clk);
        @(negedge clk); #1;
        chk("c_grant", 128'(grant), 128'(2'b01));
        push(0, 1, 0, a0, d0, m0); rst = 1'b1; #1;
        chk("midrst_grant", 128'(grant), 128'(2'b00));
        chk("midrst_af_we", 128'(af_wr_en), 128'(0));
        chk("midrst_af_full", 128'(rq_af_full), 128'(2'b11));
        @(negedge clk); rst = 1'b0; clr(); req = 2'b00;
        @(negedge clk); #1;
        chk("post_rst_idle", 128'(grant), 128'(2'b00));
        // contention from reset: cache first, then bypass with no gap
        newvals();
        req = 2'b11;
        @(negedge clk);
        @(negedge clk); #1;
        chk("tie_cache", 128'(grant), 128'(2'b01));
        push(0, 1, 1, a0, d0, m0); #1;
        chk("byp_blocked0", 128'(rq_af_full), 128'(2'b10));
        chk("c_addr", 128'(af_addr_din), 128'(a0));
        @(negedge clk); push(0, 0, 1, a0, d1, m1); req[0] = 1'b0; #1;
        chk("byp_blocked1", 128'(rq_af_full[1]), 128'(1));
        chk("c_data1", wdf_din, d1);
        @(negedge clk); clr(); #1;
        chk("no_gap", 128'(grant), 128'(2'b10));
        // backpressure on the bypass second beat
        push(1, 1, 1, a1, d0, m0); #1;
        chk("bp_af_we", 128'(af_wr_en), 128'(1));
        @(negedge clk); push(1, 0, 1, a1, d1, m1); wdf_full = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_wdf_we", 128'(wdf_wr_en), 128'(0));
            chk("bp_grant", 128'(grant), 128'(2'b10));
            chk("bp_rq_full", 128'(rq_wdf_full), 128'(2'b11));
            @(negedge clk);
        end
        wdf_full = 1'b0; req = 2'b00; #1;
        chk("bp_accept", 128'(wdf_wr_en), 128'(1));
        chk("bp_data", wdf_din, d1);
        @(negedge clk); clr(); #1;
        chk("bp_release", 128'(grant), 128'(2'b00));
        // cache read
        newvals();
        req = 2'b01; is_rd = 2'b01;
        @(negedge clk);
        @(negedge clk); #1;
        chk("rd_grant", 128'(grant), 128'(2'b01));
        push(0, 1, 0, a0, d0, m0); #1;
        chk("rd_af_we", 128'(af_wr_en), 128'(1));
        chk("rd_wdf_we", 128'(wdf_wr_en), 128'(0));
        @(negedge clk); clr(); req = 2'b00; is_rd = 2'b00; #1;
        chk("rd_release", 128'(grant), 128'(2'b00));
        chk("rd_wdf_idle", 128'(wdf_wr_en), 128'(0));
        // protocol error from the non-granted bypass
        newvals();
        chk("pe_clear", 128'(proto_err), 128'(0));
        req = 2'b01;
        @(negedge clk);
        @(negedge clk);
        push(0, 1, 1, a0, d0, m0); push(1, 1, 0, a1, d1, m1); #1;
        chk("pe_mux_addr", 128'(af_addr_din), 128'(a0));
        chk("pe_af_we", 128'(af_wr_en), 128'(1));
        @(negedge clk); push(1, 0, 0, a1, d1, m1); push(0, 0, 1, a0, d1, m1); req = 2'b00; #1;
        chk("pe_set", 128'(proto_err), 128'(1));
        @(negedge clk); clr();
        repeat (3) @(negedge clk);
        #1;
        chk("pe_sticky", 128'(proto_err), 128'(1));
        rst = 1'b1; #1;
        chk("pe_rst", 128'(proto_err), 128'(0));
        @(negedge clk); rst = 1'b0;
        // random phase: two well-behaved agents, scoreboard on controller side
        own = -1; exp_nx = -1; max_wt = 0; sb_b = 0; sb_af = 0; sb_rd = 0;
        for (int i = 0; i < 2; i++) begin
            act[i] = 0; acc_af[i] = 0; acc_wd[i] = 0; gap[i] = 0; ndone[i] = 0;
        end
        for (int cy = 0; cy < 4000; cy++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (act[i]) begin
                    if (acc_af[i]) begin af_s[i] = 1; af_we[i] = 0; end
                    if (acc_wd[i]) begin bs[i]++; wd_we[i] = 0; end
                    wt[i]++;
                    if (wt[i] > max_wt) max_wt = wt[i];
                    if (af_s[i] && (rd_t[i] || bs[i] == 2)) begin
                        act[i] = 0; req[i] = 0; gap[i] = $urandom_range(0, 4); ndone[i]++;
                    end
                end else if (gap[i] > 0) gap[i]--;
                else begin
                    act[i] = 1; req[i] = 1; rd_t[i] = $urandom_range(0, 2) == 0; is_rd[i] = rd_t[i];
                    t_a[i] = AW'(rnd()); t_a[i][AW-1] = i[0];
                    for (int k = 0; k < 2; k++) begin
                        t_d[i][k] = rnd(); t_d[i][k][DW-1] = i[0]; t_m[i][k] = MW'(rnd());
                    end
                    af_s[i] = 0; bs[i] = 0; wt[i] = 0;
                end
                if (act[i] && grant[i]) begin
                    if (!af_s[i] && !af_we[i] && $urandom_range(0, 1) == 1) begin
                        af_we[i] = 1; af_d[i*AW +: AW] = t_a[i];
                    end
                    if (!rd_t[i] && bs[i] < 2 && !wd_we[i] && $urandom_range(0, 1) == 1) begin
                        wd_we[i] = 1; wd_d[i*DW +: DW] = t_d[i][bs[i]]; wm_d[i*MW +: MW] = t_m[i][bs[i]];
                    end
                end
            end
            af_full = $urandom_range(0, 3) == 0;
            wdf_full = $urandom_range(0, 3) == 0;
            #4;
            if (af_wr_en) begin
                tg = int'(af_addr_din[AW-1]);
                start(tg);
                chk("sb_af_dup", 128'(sb_af), 128'(0));
                chk("sb_af", 128'(af_addr_din), 128'(t_a[own]));
                sb_af = 1;
            end
            if (wdf_wr_en) begin
                tg = int'(wdf_din[DW-1]);
                start(tg);
                chk("sb_rd_wdf", 128'(sb_rd), 128'(0));
                chk("sb_wd", wdf_din, sb_b < 2 ? t_d[own][sb_b] : '0);
                chk("sb_wm", 128'(wdf_mask_din), 128'(sb_b < 2 ? t_m[own][sb_b] : '0));
                sb_b++;
            end
            if (own >= 0 && sb_af && (sb_rd || sb_b == 2)) begin
                exp_nx = req[1-own] ? 1 - own : -1;
                own = -1;
            end
            for (int i = 0; i < 2; i++) begin
                acc_af[i] = af_we[i] & ~rq_af_full[i];
                acc_wd[i] = wd_we[i] & ~rq_wdf_full[i];
            end
        end
        chk("rand_proto_clean", 128'(proto_err), 128'(0));
        chk("rand_progress", 128'(ndone[0] > 20 && ndone[1] > 20), 128'(1));
        chk("rand_max_wait", 128'(max_wt < 200), 128'(1));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
